clk_switch_ctrl: RTL and testbench

- Break-before-make sequencer for a two-source glitch-free clock mux.
- Runs on the always-on reference clock and drives the gate enable of each source-clock branch.
- Each branch returns an asynchronous gate-status acknowledge, which is resynchronised through `sync` chains.
- Guarantees that both gate enables are never high together; reports switch progress to software/top level.

---
 rtl/clk_switch_pkg.sv | 21 ++
 rtl/clk_switch_ctrl_if.sv | 36 +++
 rtl/sync.sv | 37 +++
 rtl/clk_switch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_switch_pkg
//  Purpose  : Shared types and constants for the clk_switch_ctrl
//             break-before-make clock-switch sequencer.
//  Contents : state_e                - sequencer state, 2-bit encoding
//             c_sync_stages_default  - default acknowledge synchroniser depth
//  Revision : 1.0  initial release
// ============================================================================
package clk_switch_pkg;

    typedef enum logic [1:0] {
        ST_ON       = 2'd0,  // current source enabled, idle
        ST_OFF_WAIT = 2'd1,  // both gates closed, waiting for current ack low
        ST_ON_WAIT  = 2'd2   // target gate opened, waiting for target ack high
    } state_e;

    localparam int c_sync_stages_default = 2;

endpackage : clk_switch_pkg
`default_nettype wire

// File: rtl/clk_switch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_switch_ctrl_if
//  Purpose  : Request / gate-control bundle between clk_switch_ctrl and the
//             clock-mux branches plus the software-facing status.
//  Modports : master - the sequencer (drives enables and status)
//             slave  - the environment (drives sel_i and gate acknowledges)
//  Signals  : sel_i, ack0_i, ack1_i           -> into the sequencer
//             en0_o, en1_o, cur_sel_o,
//             busy_o, done_o, timeout_o       <- out of the sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface clk_switch_ctrl_if;

    logic sel_i;
    logic ack0_i;
    logic ack1_i;
    logic en0_o;
    logic en1_o;
    logic cur_sel_o;
    logic busy_o;
    logic done_o;
    logic timeout_o;

    modport master (
        input  sel_i, ack0_i, ack1_i,
        output en0_o, en1_o, cur_sel_o, busy_o, done_o, timeout_o
    );

    modport slave (
        output sel_i, ack0_i, ack1_i,
        input  en0_o, en1_o, cur_sel_o, busy_o, done_o, timeout_o
    );

endinterface : clk_switch_ctrl_if
`default_nettype wire

// File: rtl/sync.sv
`default_nettype none
// ============================================================================
//  Module   : sync
//  Purpose  : Multi-flop synchroniser for a single asynchronous level.
//  Params   : STAGES      - number of flops in the chain (>= 1)
//             RESET_VALUE - value loaded into every flop during reset
//  Ports    : clk_in  in   destination clock
//             rst_ni  in   asynchronous active-low reset
//             d_i     in   asynchronous input level
//             q_o     out  synchronised level
//  Revision : 1.0  initial release
// ============================================================================
module sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  wire logic clk_in,
    input  wire logic rst_ni,
    input  wire logic d_i,
    output logic      q_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk_in or negedge rst_ni) begin
        if (!rst_ni) begin
            r_chain <= {STAGES{RESET_VALUE}};
        end else begin
            // New sample enters bit 0 and ripples toward the MSB.
            r_chain <= (r_chain << 1) | STAGES'(d_i);
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule : sync
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_switch_ctrl
//  Purpose  : Break-before-make sequencer for a two-source glitch-free clock
//             mux. Runs on the always-on reference clock, closes the current
//             branch gate, waits for its (resynchronised) acknowledge to drop,
//             then opens the target gate and waits for it to report running.
//  Params   : SYNC_STAGES    - flops per acknowledge synchroniser
//             RESET_SEL      - source enabled out of reset (0/1)
//             TIMEOUT_W      - watchdog counter width
//             TIMEOUT_CYCLES - cycles allowed per wait state (< 2**TIMEOUT_W)
//  Ports    : clk_in  in   always-on reference clock
//             rst_ni  in   asynchronous active-low reset
//             bus     ifc  clk_switch_ctrl_if.master (sel_i, ack0_i, ack1_i,
//                          en0_o, en1_o, cur_sel_o, busy_o, done_o, timeout_o)
//  Options  : CLKSW_TIMEOUT_EN - when defined, a watchdog forces each wait
//             state forward after TIMEOUT_CYCLES and sets a sticky timeout_o.
//             When undefined the wait states wait indefinitely and timeout_o
//             is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int SYNC_STAGES    = c_sync_stages_default,
    parameter bit RESET_SEL      = 1'b0,
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  wire logic         clk_in,
    input  wire logic         rst_ni,
    clk_switch_ctrl_if.master bus
);

    logic   w_ack0_s;
    logic   w_ack1_s;
    state_e r_state;
    logic   r_cur;
    logic   r_tgt;
    logic   r_en0;
    logic   r_en1;
    logic   r_busy;
    logic   r_done;

    logic   w_ack_cur;
    logic   w_ack_tgt;
    logic   w_wait;
    logic   w_ack_seen;
    logic   w_wdog_fire;
    logic   w_advance;

    sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_ack0 (
        .clk_in (clk_in),
        .rst_ni (rst_ni),
        .d_i    (bus.ack0_i),
        .q_o    (w_ack0_s)
    );

    sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_ack1 (
        .clk_in (clk_in),
        .rst_ni (rst_ni),
        .d_i    (bus.ack1_i),
        .q_o    (w_ack1_s)
    );

    assign w_ack_cur  = r_cur ? w_ack1_s : w_ack0_s;
    assign w_ack_tgt  = r_tgt ? w_ack1_s : w_ack0_s;
    assign w_wait     = (r_state != ST_ON);
    // The awaited acknowledge for whichever wait state we are in.
    assign w_ack_seen = ((r_state == ST_OFF_WAIT) && !w_ack_cur) ||
                        ((r_state == ST_ON_WAIT)  &&  w_ack_tgt);
    assign w_advance  = w_ack_seen || (w_wait && w_wdog_fire);

`ifdef CLKSW_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] c_wdog_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_wdog;
    logic                 r_timeout;

    assign w_wdog_fire = (r_wdog == c_wdog_last);

    // Counter is zero in ON and on every wait-state entry, so each wait
    // state gets its own full budget.
    always_ff @(posedge clk_in or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_wait || w_advance) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
            // Only flag when the budget, not the ack, caused the advance.
            if (w_wait && w_wdog_fire && !w_ack_seen) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    assign w_wdog_fire   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // Enables are registered and only ever raised from a state where both
    // are already low, so they can never overlap.
    always_ff @(posedge clk_in or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_ON;
            r_cur   <= RESET_SEL;
            r_tgt   <= RESET_SEL;
            r_en0   <= ~RESET_SEL;
            r_en1   <= RESET_SEL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_ON: begin
                    if (bus.sel_i != r_cur) begin
                        r_tgt   <= bus.sel_i;
                        r_en0   <= 1'b0;
                        r_en1   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_OFF_WAIT;
                    end
                end
                ST_OFF_WAIT: begin
                    if (w_advance) begin
                        r_en0   <= ~r_tgt;
                        r_en1   <= r_tgt;
                        r_state <= ST_ON_WAIT;
                    end
                end
                ST_ON_WAIT: begin
                    if (w_advance) begin
                        r_cur   <= r_tgt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_ON;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe closed state
                    // and let OFF_WAIT re-run the handshake toward r_tgt.
                    r_en0   <= 1'b0;
                    r_en1   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ST_OFF_WAIT;
                end
            endcase
        end
    end

    assign bus.en0_o     = r_en0;
    assign bus.en1_o     = r_en1;
    assign bus.cur_sel_o = r_cur;
    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;

endmodule : clk_switch_ctrl
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_switch_ctrl
//  Purpose  : Self-checking bench for clk_switch_ctrl. A gate model returns
//             each ack three source-clock cycles after its enable; expected
//             final selections are queued when a switch is requested and
//             checked on each done pulse. Build with +define+CLKSW_TIMEOUT_EN
//             to exercise the watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_switch_ctrl;

    localparam int c_sync    = 2;
    localparam int c_tmo     = 200;
    localparam int c_budget  = 300;

    logic clk    = 1'b0;
    logic clk_s0 = 1'b0;
    logic clk_s1 = 1'b0;
    logic rst_n  = 1'b0;
    logic stuck0 = 1'b0;

    logic [2:0] sh0 = 3'b111;
    logic [2:0] sh1 = 3'b000;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cyc_ack0_fall = -1;
    int cyc_en1_rise  = -1;
    bit exp_q[$];

    clk_switch_ctrl_if bus0 ();
    clk_switch_ctrl_if bus1 ();

    clk_switch_ctrl #(
        .SYNC_STAGES(c_sync), .RESET_SEL(1'b0),
        .TIMEOUT_W(8), .TIMEOUT_CYCLES(c_tmo)
    ) dut0 (
        .clk_in (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    clk_switch_ctrl #(
        .SYNC_STAGES(c_sync), .RESET_SEL(1'b1),
        .TIMEOUT_W(8), .TIMEOUT_CYCLES(c_tmo)
    ) dut1 (
        .clk_in (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    // Clocks: edges chosen so source edges never coincide with clk posedges.
    initial forever #5 clk = ~clk;
    initial forever #4 clk_s0 = ~clk_s0;
    initial begin #1; forever #7 clk_s1 = ~clk_s1; end

    // Gate model: ack follows enable after three source-clock cycles.
    always @(posedge clk_s0) sh0 <= {sh0[1:0], bus0.en0_o};
    always @(posedge clk_s1) sh1 <= {sh1[1:0], bus0.en1_o};
    assign bus0.ack0_i = stuck0 | sh0[2];
    assign bus0.ack1_i = sh1[2];

    assign bus1.ack0_i = 1'b0;
    assign bus1.ack1_i = 1'b1;

    always @(posedge clk) cyc = cyc + 1;
    always @(negedge bus0.ack0_i) cyc_ack0_fall = cyc;
    always @(posedge bus0.en1_o)  cyc_en1_rise  = cyc;

    // Break-before-make invariant, sampled every cycle on both DUTs.
    always @(negedge clk) begin
        n_checks = n_checks + 1;
        if ((bus0.en0_o & bus0.en1_o) !== 1'b0 || (bus1.en0_o & bus1.en1_o) !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL overlap t=%0t dut0 en0=%b en1=%b dut1 en0=%b en1=%b required no overlap",
                     $time, bus0.en0_o, bus0.en1_o, bus1.en0_o, bus1.en1_o);
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus0.done_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] v0;
        logic [5:0] v1;
        rst_n = 1'b0;
        bus0.sel_i = 1'b0;
        bus1.sel_i = 1'b1;
        repeat (3) @(negedge clk);
        v0 = {bus0.en0_o, bus0.en1_o, bus0.cur_sel_o, bus0.busy_o, bus0.done_o, bus0.timeout_o};
        v1 = {bus1.en0_o, bus1.en1_o, bus1.cur_sel_o, bus1.busy_o, bus1.done_o, bus1.timeout_o};
        n_checks = n_checks + 2;
        if (v0 !== 6'b100000) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_sel0_in_reset got %b required 100000", v0);
        end
        if (v1 !== 6'b011000) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_sel1_in_reset got %b required 011000", v1);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v0 = {bus0.en0_o, bus0.en1_o, bus0.cur_sel_o, bus0.busy_o, bus0.done_o, bus0.timeout_o};
        v1 = {bus1.en0_o, bus1.en1_o, bus1.cur_sel_o, bus1.busy_o, bus1.done_o, bus1.timeout_o};
        n_checks = n_checks + 2;
        if (v0 !== 6'b100000) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_sel0_released got %b required 100000", v0);
        end
        if (v1 !== 6'b011000) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_sel1_released got %b required 011000", v1);
        end
    endtask

    task automatic test_switch();
        bit ok;
        bit e;
        cyc_ack0_fall = -1;
        cyc_en1_rise  = -1;
        @(negedge clk);
        bus0.sel_i = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge clk);
        n_checks = n_checks + 1;
        if ({bus0.en0_o, bus0.busy_o} !== 2'b01) begin
            n_fail = n_fail + 1;
            $display("FAIL switch_en0_fall got en0=%b busy=%b required en0=0 busy=1",
                     bus0.en0_o, bus0.busy_o);
        end
        wait_done(c_budget, ok);
        n_checks = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL switch_done_timeout got no done required done within %0d", c_budget);
        end else begin
            e = exp_q.pop_front();
            n_checks = n_checks + 2;
            if (bus0.cur_sel_o !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL switch_cur_sel got %b required %b", bus0.cur_sel_o, e);
            end
            if (cyc_ack0_fall < 0 || cyc_en1_rise - cyc_ack0_fall < c_sync + 1) begin
                n_fail = n_fail + 1;
                $display("FAIL switch_bbm_latency got %0d cycles (ack0 fall at %0d) required >= %0d",
                         cyc_en1_rise - cyc_ack0_fall, cyc_ack0_fall, c_sync + 1);
            end
        end
        @(negedge clk);
        n_checks = n_checks + 1;
        if ({bus0.done_o, bus0.en0_o, bus0.en1_o, bus0.busy_o} !== 4'b0010) begin
            n_fail = n_fail + 1;
            $display("FAIL switch_after_done got done/en0/en1/busy=%b required 0010",
                     {bus0.done_o, bus0.en0_o, bus0.en1_o, bus0.busy_o});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit e;
        // Currently on source 1: request 0, wiggle sel while busy, end on 0.
        bus0.sel_i = 1'b0;
        exp_q.push_back(1'b0);
        repeat (2) @(negedge clk);
        bus0.sel_i = 1'b1;
        repeat (2) @(negedge clk);
        bus0.sel_i = 1'b0;
        wait_done(c_budget, ok);
        n_checks = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_first_done got no done required done");
        end else begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (bus0.cur_sel_o !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_first_cur got %b required %b", bus0.cur_sel_o, e);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks = n_checks + 1;
            if ({bus0.busy_o, bus0.done_o} !== 2'b00) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_no_extra_switch cycle %0d got busy=%b done=%b required 0 0",
                         i, bus0.busy_o, bus0.done_o);
            end
        end
        // Request 1, then drop sel back to 0 while busy and hold it.
        bus0.sel_i = 1'b1;
        exp_q.push_back(1'b1);
        repeat (2) @(negedge clk);
        bus0.sel_i = 1'b0;
        wait_done(c_budget, ok);
        n_checks = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_second_done got no done required done");
        end else begin
            e = exp_q.pop_front();
            exp_q.push_back(1'b0);
            n_checks = n_checks + 1;
            if (bus0.cur_sel_o !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_second_cur got %b required %b", bus0.cur_sel_o, e);
            end
        end
        @(negedge clk);
        n_checks = n_checks + 1;
        if ({bus0.busy_o, bus0.en0_o, bus0.en1_o} !== 3'b100) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_restart got busy/en0/en1=%b required 100",
                     {bus0.busy_o, bus0.en0_o, bus0.en1_o});
        end
        wait_done(c_budget, ok);
        n_checks = n_checks + 1;
        if (!ok || exp_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_third_done got done=%b queued=%0d required done", ok, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (bus0.cur_sel_o !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_third_cur got %b required %b", bus0.cur_sel_o, e);
            end
        end
    endtask

    task automatic test_idle();
        bus0.sel_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks = n_checks + 1;
            if ({bus0.busy_o, bus0.done_o, bus0.en0_o, bus0.cur_sel_o} !== 4'b0010) begin
                n_fail = n_fail + 1;
                $display("FAIL idle cycle %0d got busy/done/en0/cur=%b required 0010",
                         i, {bus0.busy_o, bus0.done_o, bus0.en0_o, bus0.cur_sel_o});
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit e;
        int n;
        stuck0 = 1'b1;
        repeat (5) @(negedge clk);
        bus0.sel_i = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge clk);
        n_checks = n_checks + 1;
        if ({bus0.en0_o, bus0.busy_o} !== 2'b01) begin
            n_fail = n_fail + 1;
            $display("FAIL tmo_enter got en0=%b busy=%b required 0 1", bus0.en0_o, bus0.busy_o);
        end
`ifdef CLKSW_TIMEOUT_EN
        n = 0;
        while (bus0.en1_o !== 1'b1 && n < 1500) begin
            @(negedge clk);
            n = n + 1;
        end
        n_checks = n_checks + 2;
        if (n != c_tmo) begin
            n_fail = n_fail + 1;
            $display("FAIL tmo_wait_cycles got %0d required %0d", n, c_tmo);
        end
        if (bus0.timeout_o !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL tmo_flag got %b required 1", bus0.timeout_o);
        end
        wait_done(c_budget, ok);
        stuck0 = 1'b0;
`else
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({bus0.en1_o, bus0.busy_o, bus0.timeout_o} !== 3'b010) n = n + 1;
        end
        n_checks = n_checks + 1;
        if (n != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL tmo_hold got %0d bad cycles (en1/busy/tmo=%b) required 0",
                     n, {bus0.en1_o, bus0.busy_o, bus0.timeout_o});
        end
        stuck0 = 1'b0;
        wait_done(c_budget, ok);
`endif
        n_checks = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL tmo_done got no done required done");
        end else begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (bus0.cur_sel_o !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL tmo_cur got %b required %b", bus0.cur_sel_o, e);
            end
        end
        repeat (10) @(negedge clk);
        n_checks = n_checks + 1;
`ifdef CLKSW_TIMEOUT_EN
        if (bus0.timeout_o !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL tmo_sticky got %b required 1", bus0.timeout_o);
        end
`else
        if (bus0.timeout_o !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL tmo_tied got %b required 0", bus0.timeout_o);
        end
`endif
    endtask

    task automatic test_async_reset();
        bit ok;
        bit e;
        int n;
        logic [5:0] v0;
        // From source 1 go to 0, then start 0 -> 1 and reset in ON_WAIT.
        bus0.sel_i = 1'b0;
        exp_q.push_back(1'b0);
        wait_done(c_budget, ok);
        n_checks = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL arst_pre_done got no done required done");
        end else begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            if (bus0.cur_sel_o !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL arst_pre_cur got %b required %b", bus0.cur_sel_o, e);
            end
        end
        bus0.sel_i = 1'b1;
        exp_q.push_back(1'b1);
        n = 0;
        while (bus0.en1_o !== 1'b1 && n < c_budget) begin
            @(negedge clk);
            n = n + 1;
        end
        n_checks = n_checks + 1;
        if ({bus0.en1_o, bus0.busy_o} !== 2'b11) begin
            n_fail = n_fail + 1;
            $display("FAIL arst_on_wait got en1=%b busy=%b required 1 1", bus0.en1_o, bus0.busy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        v0 = {bus0.en0_o, bus0.en1_o, bus0.cur_sel_o, bus0.busy_o, bus0.done_o, bus0.timeout_o};
        n_checks = n_checks + 1;
        if (v0 !== 6'b100000) begin
            n_fail = n_fail + 1;
            $display("FAIL arst_async got %b required 100000", v0);
        end
        bus0.sel_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v0 = {bus0.en0_o, bus0.en1_o, bus0.cur_sel_o, bus0.busy_o, bus0.done_o, bus0.timeout_o};
        n_checks = n_checks + 1;
        if (v0 !== 6'b100000) begin
            n_fail = n_fail + 1;
            $display("FAIL arst_released got %b required 100000", v0);
        end
    endtask

    initial begin
        bus0.sel_i = 1'b0;
        bus1.sel_i = 1'b1;
        test_reset();
        test_switch();
        test_back_to_back();
        test_idle();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got t=%0t required finish earlier", $time);
        $fatal(1, "time limit");
    end

endmodule : tb_clk_switch_ctrl
`default_nettype wire
